flp_addsub_norm: RTL and testbench

//  Post-alignment stage of the floating-point adder, fed by the exponent

---
 rtl/flp_addsub_norm.sv | 262 ++++++++++++++++++++++++++
 tb/tb_flp_addsub_norm.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flp_addsub_norm.sv
// flp_addsub_norm: post-alignment add/subtract, normalize and round stage of
// the floating-point adder. Two-stage elastic pipeline, valid/ready handshake.
//
// Optional feature macro: FLP_ADDSUB_RNE_EN
//   defined   -> round-to-nearest-even
//   undefined -> truncate (round toward zero)
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   i_valid / o_ready        input handshake
//   i_sign1, i_sign2, i_sub  operand signs and operation (1 = op1-op2)
//   i_sg1, i_sg2             aligned significands {hidden, frac, guard, sticky}
//   i_ex                     common biased exponent
//   o_valid / i_ready        output handshake
//   o_sign, o_ex, o_frac     packed result fields (hidden bit dropped)
//   o_zero                   result is zero or flushed to zero
//   o_ovf                    exponent overflow, result forced to infinity

module flp_addsub_norm #(
   parameter int EWIDTH  = 8,
   parameter int SWIDTH  = 23,
   parameter int RSWIDTH = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_valid,
   output logic                      o_ready,
   input  logic                      i_sign1,
   input  logic                      i_sign2,
   input  logic                      i_sub,
   input  logic [SWIDTH+RSWIDTH:0]   i_sg1,
   input  logic [SWIDTH+RSWIDTH:0]   i_sg2,
   input  logic [EWIDTH-1:0]         i_ex,
   output logic                      o_valid,
   input  logic                      i_ready,
   output logic                      o_sign,
   output logic [EWIDTH-1:0]         o_ex,
   output logic [SWIDTH-1:0]         o_frac,
   output logic                      o_zero,
   output logic                      o_ovf
);

   localparam int OUTWIDTH = 1 + SWIDTH + RSWIDTH;
   localparam int MW       = OUTWIDTH + 1;
   localparam int LZW      = $clog2(OUTWIDTH + 1);
   localparam int XW       = EWIDTH + 2;
   localparam int RW       = SWIDTH + 2;

   // ------------------------------------------------------------------
   // Handshake control
   // ------------------------------------------------------------------
   logic s1_v_q, s1_v_d;
   logic s2_v_q, s2_v_d;
   logic s1_load;
   logic s2_en;
   logic s2_load;

   assign s2_en   = !s2_v_q || i_ready;
   assign o_ready = !s1_v_q || !s2_v_q || i_ready;
   assign s1_load = o_ready && i_valid;
   assign s2_load = s2_en && s1_v_q;
   assign o_valid = s2_v_q;

   always_comb begin
      s1_v_d = s1_v_q;
      s2_v_d = s2_v_q;
      if (o_ready) begin
         s1_v_d = i_valid;
      end
      if (s2_en) begin
         s2_v_d = s1_v_q;
      end
   end

   // ------------------------------------------------------------------
   // S1: sign-magnitude add / subtract
   // ------------------------------------------------------------------
   logic          eff_sub;
   logic [MW-1:0] sum_c;
   logic [MW-1:0] dif12_c;
   logic [MW-1:0] dif21_c;
   logic          ge_c;
   logic [MW-1:0] mag_c;
   logic          sign_c;

   logic [MW-1:0]     s1_mag_q, s1_mag_d;
   logic              s1_sign_q, s1_sign_d;
   logic [EWIDTH-1:0] s1_ex_q, s1_ex_d;

   assign eff_sub = i_sign1 ^ i_sign2 ^ i_sub;
   assign sum_c   = {1'b0, i_sg1} + {1'b0, i_sg2};
   assign dif12_c = {1'b0, i_sg1} - {1'b0, i_sg2};
   assign dif21_c = {1'b0, i_sg2} - {1'b0, i_sg1};
   assign ge_c    = (i_sg1 >= i_sg2);

   always_comb begin
      mag_c  = sum_c;
      sign_c = i_sign1;
      if (eff_sub) begin
         if (ge_c) begin
            mag_c  = dif12_c;
            sign_c = i_sign1;
         end else begin
            mag_c  = dif21_c;
            sign_c = i_sign2 ^ i_sub;
         end
      end
      // Exact cancellation always yields +0.
      if (mag_c == '0) begin
         sign_c = 1'b0;
      end
   end

   always_comb begin
      s1_mag_d  = s1_mag_q;
      s1_sign_d = s1_sign_q;
      s1_ex_d   = s1_ex_q;
      if (s1_load) begin
         s1_mag_d  = mag_c;
         s1_sign_d = sign_c;
         s1_ex_d   = i_ex;
      end
   end

   // ------------------------------------------------------------------
   // S2: normalize
   // ------------------------------------------------------------------
   logic                carry;
   logic [LZW-1:0]      lz;
   logic [OUTWIDTH-1:0] nsig;
   logic [XW-1:0]       nex;
   logic                flush;

   assign carry = s1_mag_q[MW-1];

   // Leading-zero count below the carry bit; the highest set bit wins.
   always_comb begin
      lz = LZW'(OUTWIDTH);
      for (int i = 0; i < OUTWIDTH; i++) begin
         if (s1_mag_q[i]) begin
            lz = LZW'(OUTWIDTH - 1 - i);
         end
      end
   end

   always_comb begin
      nsig = s1_mag_q[OUTWIDTH-1:0] << lz;
      nex  = {2'b00, s1_ex_q} - XW'(lz);
      if (carry) begin
         // Right shift by one; the dropped bit is jammed into sticky.
         nsig = {s1_mag_q[MW-1:2], s1_mag_q[1] | s1_mag_q[0]};
         nex  = {2'b00, s1_ex_q} + XW'(1);
      end
   end

   // nex is a signed quantity: negative or zero means underflow.
   assign flush = (s1_ex_q == '0) || (s1_mag_q == '0) ||
                  (!carry && (nex[XW-1] || (nex == '0)));

   // ------------------------------------------------------------------
   // S2: round
   // ------------------------------------------------------------------
   logic          rnd;
   logic [RW-1:0] rsum;
   logic          rcarry;
   logic [XW-1:0] fex;
   logic          ovf;
   logic          hid_unused;

`ifdef FLP_ADDSUB_RNE_EN
   logic guard;
   logic sticky;
   logic lsb;

   assign guard  = nsig[RSWIDTH-1];
   assign sticky = |nsig[RSWIDTH-2:0];
   assign lsb    = nsig[RSWIDTH];
   assign rnd    = guard && (sticky || lsb);
`else
   logic rs_unused;

   assign rs_unused = ^nsig[RSWIDTH-1:0];
   assign rnd       = 1'b0;
`endif

   assign rsum   = {1'b0, nsig[OUTWIDTH-1:RSWIDTH]} + RW'(rnd);
   // Rounding carried past the hidden bit: significand becomes 1.0.
   assign rcarry = rsum[RW-1];
   assign fex    = nex + XW'(rcarry);
   assign ovf    = !flush && (fex >= XW'((2 ** EWIDTH) - 1));
   assign hid_unused = rsum[SWIDTH];

   // ------------------------------------------------------------------
   // Output registers
   // ------------------------------------------------------------------
   logic              o_sign_q, o_sign_d;
   logic [EWIDTH-1:0] o_ex_q, o_ex_d;
   logic [SWIDTH-1:0] o_frac_q, o_frac_d;
   logic              o_zero_q, o_zero_d;
   logic              o_ovf_q, o_ovf_d;

   always_comb begin
      o_sign_d = o_sign_q;
      o_ex_d   = o_ex_q;
      o_frac_d = o_frac_q;
      o_zero_d = o_zero_q;
      o_ovf_d  = o_ovf_q;
      if (s2_load) begin
         o_sign_d = s1_sign_q;
         o_zero_d = 1'b0;
         o_ovf_d  = 1'b0;
         o_ex_d   = fex[EWIDTH-1:0];
         o_frac_d = rcarry ? '0 : rsum[SWIDTH-1:0];
         if (flush) begin
            o_sign_d = 1'b0;
            o_zero_d = 1'b1;
            o_ex_d   = '0;
            o_frac_d = '0;
         end else if (ovf) begin
            o_ovf_d  = 1'b1;
            o_ex_d   = '1;
            o_frac_d = '0;
         end
      end
   end

   assign o_sign = o_sign_q;
   assign o_ex   = o_ex_q;
   assign o_frac = o_frac_q;
   assign o_zero = o_zero_q;
   assign o_ovf  = o_ovf_q;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_v_q    <= 1'b0;
         s2_v_q    <= 1'b0;
         s1_mag_q  <= '0;
         s1_sign_q <= 1'b0;
         s1_ex_q   <= '0;
         o_sign_q  <= 1'b0;
         o_ex_q    <= '0;
         o_frac_q  <= '0;
         o_zero_q  <= 1'b0;
         o_ovf_q   <= 1'b0;
      end else begin
         s1_v_q    <= s1_v_d;
         s2_v_q    <= s2_v_d;
         s1_mag_q  <= s1_mag_d;
         s1_sign_q <= s1_sign_d;
         s1_ex_q   <= s1_ex_d;
         o_sign_q  <= o_sign_d;
         o_ex_q    <= o_ex_d;
         o_frac_q  <= o_frac_d;
         o_zero_q  <= o_zero_d;
         o_ovf_q   <= o_ovf_d;
      end
   end

endmodule

// File: tb/tb_flp_addsub_norm.sv
// tb_flp_addsub_norm: directed self-checking bench for flp_addsub_norm.
// Expected rounding results follow FLP_ADDSUB_RNE_EN when it is defined.

module tb_flp_addsub_norm;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_valid;
   logic        o_ready;
   logic        i_sign1;
   logic        i_sign2;
   logic        i_sub;
   logic [25:0] i_sg1;
   logic [25:0] i_sg2;
   logic [7:0]  i_ex;
   logic        o_valid;
   logic        i_ready;
   logic        o_sign;
   logic [7:0]  o_ex;
   logic [22:0] o_frac;
   logic        o_zero;
   logic        o_ovf;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   flp_addsub_norm #(
      .EWIDTH  (8),
      .SWIDTH  (23),
      .RSWIDTH (2)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_sign1 (i_sign1),
      .i_sign2 (i_sign2),
      .i_sub   (i_sub),
      .i_sg1   (i_sg1),
      .i_sg2   (i_sg2),
      .i_ex    (i_ex),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_sign  (o_sign),
      .o_ex    (o_ex),
      .o_frac  (o_frac),
      .o_zero  (o_zero),
      .o_ovf   (o_ovf)
   );

   // Sends one operand set and waits (bounded) for its result.
   task automatic run_one(
      input  logic        s1,
      input  logic        s2,
      input  logic        sub,
      input  logic [25:0] a,
      input  logic [25:0] b,
      input  logic [7:0]  ex,
      output logic        r_sign,
      output logic [7:0]  r_ex,
      output logic [22:0] r_frac,
      output logic        r_zero,
      output logic        r_ovf,
      output int          lat
   );
      int n;
      @(negedge clk);
      i_sign1 = s1;
      i_sign2 = s2;
      i_sub   = sub;
      i_sg1   = a;
      i_sg2   = b;
      i_ex    = ex;
      i_valid = 1'b1;
      i_ready = 1'b1;
      #1;
      n = 0;
      while (!o_ready && n < 10) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!o_ready) begin
         checks++;
         failures++;
         $display("FAIL input_timeout o_ready=%b required=1", o_ready);
      end
      @(negedge clk);
      i_valid = 1'b0;
      lat = 1;
      n = 0;
      while (!o_valid && n < 10) begin
         @(negedge clk);
         lat++;
         n++;
      end
      if (!o_valid) begin
         checks++;
         failures++;
         $display("FAIL output_timeout o_valid=%b required=1", o_valid);
      end
      r_sign = o_sign;
      r_ex   = o_ex;
      r_frac = o_frac;
      r_zero = o_zero;
      r_ovf  = o_ovf;
   endtask

   task automatic test_reset();
      rst     = 1'b1;
      i_valid = 1'b0;
      i_ready = 1'b1;
      i_sign1 = 1'b0;
      i_sign2 = 1'b0;
      i_sub   = 1'b0;
      i_sg1   = '0;
      i_sg2   = '0;
      i_ex    = '0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (o_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_valid got=%b exp=0", o_valid);
      end
      checks++;
      if ({o_sign, o_ex, o_frac, o_zero, o_ovf} !== 34'd0) begin
         failures++;
         $display("FAIL reset_data got=%h exp=0",
                  {o_sign, o_ex, o_frac, o_zero, o_ovf});
      end
      checks++;
      if (o_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_ready got=%b exp=1", o_ready);
      end
      rst = 1'b0;
   endtask

   task automatic test_add();
      logic sg, z, ov;
      logic [7:0] e;
      logic [22:0] f;
      int lat;
      run_one(0, 0, 0, 26'h2000000, 26'h2000000, 8'd127,
              sg, e, f, z, ov, lat);
      checks++;
      if ({sg, e, f, z, ov} !== {1'b0, 8'd128, 23'd0, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL add_1p1 got s=%b e=%0d f=%h z=%b o=%b exp s=0 e=128 f=0 z=0 o=0",
                  sg, e, f, z, ov);
      end
      checks++;
      if (lat !== 2) begin
         failures++;
         $display("FAIL add_latency got=%0d exp=2", lat);
      end
   endtask

   task automatic test_sub();
      logic sg, z, ov;
      logic [7:0] e;
      logic [22:0] f;
      int lat;
      run_one(0, 0, 1, 26'h2000000, 26'h2000000, 8'd127,
              sg, e, f, z, ov, lat);
      checks++;
      if ({sg, e, f, z, ov} !== {1'b0, 8'd0, 23'd0, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL sub_cancel got s=%b e=%0d f=%h z=%b o=%b exp s=0 e=0 f=0 z=1 o=0",
                  sg, e, f, z, ov);
      end
      run_one(0, 0, 1, 26'h3000000, 26'h2000000, 8'd127,
              sg, e, f, z, ov, lat);
      checks++;
      if ({sg, e, f, z, ov} !== {1'b0, 8'd126, 23'd0, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL sub_1p5m1 got s=%b e=%0d f=%h z=%b o=%b exp s=0 e=126 f=0 z=0 o=0",
                  sg, e, f, z, ov);
      end
      run_one(0, 0, 1, 26'h2000000, 26'h3000000, 8'd127,
              sg, e, f, z, ov, lat);
      checks++;
      if ({sg, e, f, z, ov} !== {1'b1, 8'd126, 23'd0, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL sub_1m1p5 got s=%b e=%0d f=%h z=%b o=%b exp s=1 e=126 f=0 z=0 o=0",
                  sg, e, f, z, ov);
      end
      // -1.0 + 1.5 = +0.5
      run_one(1, 0, 0, 26'h2000000, 26'h3000000, 8'd127,
              sg, e, f, z, ov, lat);
      checks++;
      if ({sg, e, f, z, ov} !== {1'b0, 8'd126, 23'd0, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL sub_neg_add got s=%b e=%0d f=%h z=%b o=%b exp s=0 e=126 f=0 z=0 o=0",
                  sg, e, f, z, ov);
      end
   endtask

   task automatic test_round();
      logic sg, z, ov;
      logic [7:0] e;
      logic [22:0] f;
      int lat;
      logic [25:0] vin [6];
      logic [25:0] vin2 [6];
      logic [22:0] ef [6];
      logic [7:0]  ee [6];
      vin[0] = 26'h2000003;  vin2[0] = 26'h0;
      vin[1] = 26'h2000002;  vin2[1] = 26'h0;
      vin[2] = 26'h2000006;  vin2[2] = 26'h0;
      vin[3] = 26'h3FFFFFE;  vin2[3] = 26'h0;
      vin[4] = 26'h2000004;  vin2[4] = 26'h2000001;
      vin[5] = 26'h3FFFFFF;  vin2[5] = 26'h0;
`ifdef FLP_ADDSUB_RNE_EN
      ef[0] = 23'd1;  ee[0] = 8'd127;
      ef[1] = 23'd0;  ee[1] = 8'd127;
      ef[2] = 23'd2;  ee[2] = 8'd127;
      ef[3] = 23'd0;  ee[3] = 8'd128;
      ef[4] = 23'd1;  ee[4] = 8'd128;
      ef[5] = 23'd0;  ee[5] = 8'd128;
`else
      ef[0] = 23'd0;        ee[0] = 8'd127;
      ef[1] = 23'd0;        ee[1] = 8'd127;
      ef[2] = 23'd1;        ee[2] = 8'd127;
      ef[3] = 23'h7FFFFF;   ee[3] = 8'd127;
      ef[4] = 23'd0;        ee[4] = 8'd128;
      ef[5] = 23'h7FFFFF;   ee[5] = 8'd127;
`endif
      for (int k = 0; k < 6; k++) begin
         run_one(0, 0, 0, vin[k], vin2[k], 8'd127,
                 sg, e, f, z, ov, lat);
         checks++;
         if ({sg, e, f, z, ov} !== {1'b0, ee[k], ef[k], 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL round_%0d got s=%b e=%0d f=%h z=%b o=%b exp s=0 e=%0d f=%h z=0 o=0",
                     k, sg, e, f, z, ov, ee[k], ef[k]);
         end
      end
   endtask

   task automatic test_flush();
      logic sg, z, ov;
      logic [7:0] e;
      logic [22:0] f;
      int lat;
      run_one(0, 0, 1, 26'h3000000, 26'h2000000, 8'd1,
              sg, e, f, z, ov, lat);
      checks++;
      if ({sg, e, f, z, ov} !== {1'b0, 8'd0, 23'd0, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL flush_underflow got s=%b e=%0d f=%h z=%b o=%b exp s=0 e=0 f=0 z=1 o=0",
                  sg, e, f, z, ov);
      end
      run_one(1, 1, 0, 26'h2000000, 26'h2000000, 8'd0,
              sg, e, f, z, ov, lat);
      checks++;
      if ({sg, e, f, z, ov} !== {1'b0, 8'd0, 23'd0, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL flush_ex0 got s=%b e=%0d f=%h z=%b o=%b exp s=0 e=0 f=0 z=1 o=0",
                  sg, e, f, z, ov);
      end
   endtask

   task automatic test_ovf();
      logic sg, z, ov;
      logic [7:0] e;
      logic [22:0] f;
      int lat;
      run_one(0, 0, 0, 26'h2000000, 26'h2000000, 8'd254,
              sg, e, f, z, ov, lat);
      checks++;
      if ({sg, e, f, z, ov} !== {1'b0, 8'd255, 23'd0, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL ovf_254 got s=%b e=%0d f=%h z=%b o=%b exp s=0 e=255 f=0 z=0 o=1",
                  sg, e, f, z, ov);
      end
      run_one(1, 0, 1, 26'h3000000, 26'h2000000, 8'd253,
              sg, e, f, z, ov, lat);
      checks++;
      if ({sg, e, f, z, ov} !== {1'b1, 8'd254, 23'h200000, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL ovf_edge got s=%b e=%0d f=%h z=%b o=%b exp s=1 e=254 f=200000 z=0 o=0",
                  sg, e, f, z, ov);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0]  ex_got [3];
      logic [22:0] fr_got [3];
      logic [7:0]  ex_exp [3];
      logic [22:0] fr_exp [3];
      int   got;
      int   bad;
      logic acc;
      ex_exp[0] = 8'd128;  fr_exp[0] = 23'd0;
      ex_exp[1] = 8'd126;  fr_exp[1] = 23'd0;
      ex_exp[2] = 8'd100;
`ifdef FLP_ADDSUB_RNE_EN
      fr_exp[2] = 23'd2;
`else
      fr_exp[2] = 23'd1;
`endif
      @(negedge clk);
      i_ready = 1'b0;
      i_sign1 = 1'b0;
      i_sign2 = 1'b0;
      i_sub   = 1'b0;
      i_sg1   = 26'h2000000;
      i_sg2   = 26'h2000000;
      i_ex    = 8'd127;
      i_valid = 1'b1;
      #1;
      checks++;
      if (o_ready !== 1'b1) begin
         failures++;
         $display("FAIL bp_ready_empty got=%b exp=1", o_ready);
      end
      @(negedge clk);
      i_sub = 1'b1;
      i_sg1 = 26'h3000000;
      #1;
      @(negedge clk);
      i_sub = 1'b0;
      i_sg1 = 26'h2000006;
      i_sg2 = 26'h0;
      i_ex  = 8'd100;
      #1;
      checks++;
      if (o_ready !== 1'b0) begin
         failures++;
         $display("FAIL bp_ready_full got=%b exp=0", o_ready);
      end
      bad = 0;
      for (int k = 0; k < 3; k++) begin
         if (!(o_valid === 1'b1 && o_ex === 8'd128 &&
               o_frac === 23'd0 && o_ready === 1'b0)) begin
            bad++;
         end
         if (k < 2) begin
            @(negedge clk);
            #1;
         end
      end
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL bp_stable got=%0d unstable cycles exp=0", bad);
      end
      i_ready = 1'b1;
      #1;
      got = 0;
      for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
         if (o_valid) begin
            ex_got[got] = o_ex;
            fr_got[got] = o_frac;
            got++;
         end
         acc = i_valid && o_ready;
         @(negedge clk);
         if (acc) i_valid = 1'b0;
         #1;
      end
      checks++;
      if (got !== 3) begin
         failures++;
         $display("FAIL bp_count got=%0d exp=3", got);
      end
      for (int k = 0; k < got; k++) begin
         checks++;
         if (ex_got[k] !== ex_exp[k] || fr_got[k] !== fr_exp[k]) begin
            failures++;
            $display("FAIL bp_order_%0d got e=%0d f=%h exp e=%0d f=%h",
                     k, ex_got[k], fr_got[k], ex_exp[k], fr_exp[k]);
         end
      end
      checks++;
      if (o_valid !== 1'b0) begin
         failures++;
         $display("FAIL bp_dup got o_valid=%b exp=0", o_valid);
      end
   endtask

   task automatic test_reset_mid();
      int seen;
      @(negedge clk);
      i_sign1 = 1'b0;
      i_sign2 = 1'b0;
      i_sub   = 1'b0;
      i_sg1   = 26'h2000000;
      i_sg2   = 26'h2000000;
      i_ex    = 8'd127;
      i_valid = 1'b1;
      i_ready = 1'b1;
      @(negedge clk);
      i_valid = 1'b0;
      rst     = 1'b1;
      @(negedge clk);
      rst  = 1'b0;
      seen = 0;
      for (int k = 0; k < 4; k++) begin
         if (o_valid !== 1'b0) seen++;
         @(negedge clk);
      end
      checks++;
      if (seen !== 0) begin
         failures++;
         $display("FAIL reset_mid got=%0d valid cycles exp=0", seen);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_round();
      test_flush();
      test_ovf();
      test_backpressure();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
